// File: rtl/vtc_pkg.sv
`default_nettype none
// ============================================================================
// vtc_pkg : shared types for the vector test controller
// Rev 1.0
// ============================================================================
package vtc_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    WAIT  = 3'd3,
    CHECK = 3'd4,
    DONE  = 3'd5
  } state_t;

  function automatic int vec_width(input int nin, input int nout);
    return nin + nout;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vtc_result_tracker.sv
`default_nettype none
// ============================================================================
// vtc_result_tracker : per-run pass/fail statistics for the vector controller
// Rev 1.0
// ============================================================================
module vtc_result_tracker #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_i,
  input  logic          check_en_i,
  input  logic          mismatch_i,
  input  logic [AW-1:0] idx_i,
  output logic [AW:0]   err_count_o,
  output logic [AW:0]   tested_count_o,
  output logic          fail_valid_o,
  output logic [AW-1:0] first_fail_idx_o
);

  logic [AW:0]   err_q;
  logic [AW:0]   tested_q;
  logic          fail_valid_q;
  logic [AW-1:0] first_fail_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q        <= '0;
      tested_q     <= '0;
      fail_valid_q <= 1'b0;
      first_fail_q <= '0;
    end else if (clear_i) begin
      err_q        <= '0;
      tested_q     <= '0;
      fail_valid_q <= 1'b0;
      first_fail_q <= '0;
    end else if (check_en_i) begin
      tested_q <= tested_q + 1'b1;
      if (mismatch_i) begin
        // Error count sticks at all-ones rather than wrapping to a false pass.
        if (err_q != '1) err_q <= err_q + 1'b1;
        if (!fail_valid_q) begin
          fail_valid_q <= 1'b1;
          first_fail_q <= idx_i;
        end
      end
    end
  end

  assign err_count_o      = err_q;
  assign tested_count_o   = tested_q;
  assign fail_valid_o     = fail_valid_q;
  assign first_fail_idx_o = first_fail_q;

endmodule
`default_nettype wire

// File: rtl/vector_test_controller.sv
`default_nettype none
// ============================================================================
// vector_test_controller : fetches {inputs, expected} vectors, applies them,
// waits SETTLE cycles and checks the DUT response.  Rev 1.0
// ============================================================================
module vector_test_controller
  import vtc_pkg::*;
#(
  parameter int NIN          = 3,
  parameter int NOUT         = 1,
  parameter int DEPTH        = 16,
  parameter int AW           = $clog2(DEPTH),
  parameter int SETTLE       = 1,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [AW:0]              num_vectors,
  output logic [AW-1:0]            mem_addr,
  input  logic [NIN+NOUT-1:0]      mem_rdata,
  output logic [NIN-1:0]           dut_in,
  input  logic [NOUT-1:0]          dut_out,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [AW:0]              err_count,
  output logic                     fail_valid,
  output logic [AW-1:0]            first_fail_idx,
  output logic [AW:0]              tested_count
);

  localparam int          VW      = vec_width(NIN, NOUT);
  localparam int          CW      = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE - 1);

  state_t          state_q, state_d;
  logic [AW-1:0]   idx_q;
  logic [AW:0]     nv_q;
  logic [CW-1:0]   cnt_q;
  logic [AW-1:0]   mem_addr_q;
  logic [NIN-1:0]  dut_in_q;
  logic [NOUT-1:0] exp_q;

  logic            w_start_ok;
  logic [AW:0]     w_nv_clamp;
  logic            w_mismatch;
  logic            w_last;

  assign w_start_ok = start && (state_q == IDLE || state_q == DONE);
  assign w_nv_clamp = (num_vectors > DEPTH_C) ? DEPTH_C : num_vectors;
  // Case inequality so an X on the DUT output is reported as a failure.
  assign w_mismatch = (dut_out !== exp_q);
  assign w_last     = ({1'b0, idx_q} == (nv_q - 1'b1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = (w_nv_clamp == '0) ? DONE : FETCH;
      FETCH:      state_d = LOAD;
      LOAD:       state_d = WAIT;
      WAIT:       if (cnt_q == '0) state_d = CHECK;
      CHECK:      state_d = ((w_mismatch && STOP_ON_FAIL) || w_last) ? DONE : FETCH;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == FETCH) || (state_q == LOAD) ||
           (state_q == WAIT)  || (state_q == CHECK);
    done = (state_q == DONE);
    pass = done && (err_count == '0);
  end

  // The address is presented on entry to FETCH so the synchronous memory
  // returns the vector in time for LOAD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q      <= '0;
      nv_q       <= '0;
      cnt_q      <= '0;
      mem_addr_q <= '0;
      dut_in_q   <= '0;
      exp_q      <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            idx_q      <= '0;
            nv_q       <= w_nv_clamp;
            mem_addr_q <= '0;
          end
        end
        LOAD: begin
          dut_in_q <= mem_rdata[VW-1:NOUT];
          exp_q    <= mem_rdata[NOUT-1:0];
          cnt_q    <= SETTLE_LOAD;
        end
        WAIT: if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        CHECK: begin
          if (state_d == FETCH) begin
            idx_q      <= idx_q + 1'b1;
            mem_addr_q <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr = mem_addr_q;
  assign dut_in   = dut_in_q;

  vtc_result_tracker #(
    .AW (AW)
  ) u_tracker (
    .clk              (clk),
    .rst              (reset),
    .clear_i          (w_start_ok),
    .check_en_i       (state_q == CHECK),
    .mismatch_i       (w_mismatch),
    .idx_i            (idx_q),
    .err_count_o      (err_count),
    .tested_count_o   (tested_count),
    .fail_valid_o     (fail_valid),
    .first_fail_idx_o (first_fail_idx)
  );

endmodule
`default_nettype wire

// File: tb/tb_vector_test_controller.sv
`default_nettype none
// ============================================================================
// tb_vector_test_controller : directed checks of the vector test controller
// Rev 1.0
// ============================================================================
module tb_vector_test_controller;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [3:0] mem [16];
  logic       dly = 1'b0;

  // Instance A: SETTLE=1, STOP_ON_FAIL=0
  logic       a_start = 1'b0;
  logic [4:0] a_num = '0;
  logic [3:0] a_addr, a_rdata, a_ffi;
  logic [2:0] a_dut_in;
  logic       a_out, a_d1, a_d2;
  logic       a_busy, a_done, a_pass, a_fv;
  logic [4:0] a_err, a_tested;

  // Instance B: SETTLE=3, STOP_ON_FAIL=1
  logic       b_start = 1'b0;
  logic [4:0] b_num = '0;
  logic [3:0] b_addr, b_rdata, b_ffi;
  logic [2:0] b_dut_in;
  logic       b_out, b_d1, b_d2;
  logic       b_busy, b_done, b_pass, b_fv;
  logic [4:0] b_err, b_tested;

  always @(posedge clk) begin
    a_rdata <= mem[a_addr];
    b_rdata <= mem[b_addr];
    a_d1 <= ^a_dut_in;
    a_d2 <= a_d1;
    b_d1 <= ^b_dut_in;
    b_d2 <= b_d1;
  end
  assign a_out = dly ? a_d2 : ^a_dut_in;
  assign b_out = dly ? b_d2 : ^b_dut_in;

  vector_test_controller u_a (
    .clk(clk), .reset(reset), .start(a_start), .num_vectors(a_num),
    .mem_addr(a_addr), .mem_rdata(a_rdata), .dut_in(a_dut_in), .dut_out(a_out),
    .busy(a_busy), .done(a_done), .pass(a_pass), .err_count(a_err),
    .fail_valid(a_fv), .first_fail_idx(a_ffi), .tested_count(a_tested)
  );

  vector_test_controller #(.SETTLE(3), .STOP_ON_FAIL(1'b1)) u_b (
    .clk(clk), .reset(reset), .start(b_start), .num_vectors(b_num),
    .mem_addr(b_addr), .mem_rdata(b_rdata), .dut_in(b_dut_in), .dut_out(b_out),
    .busy(b_busy), .done(b_done), .pass(b_pass), .err_count(b_err),
    .fail_valid(b_fv), .first_fail_idx(b_ffi), .tested_count(b_tested)
  );

  function automatic logic [3:0] good_vec(input int i);
    logic [2:0] v;
    v = i[2:0];
    return {v, ^v};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start on the selected instance; cycles = edges after the start
  // edge until done is seen, or -1 if the bound expires.
  task automatic run(input bit sel, input logic [4:0] nv, output int cycles);
    tick();
    if (sel) begin b_num = nv; b_start = 1'b1; end
    else     begin a_num = nv; a_start = 1'b1; end
    tick();
    a_start = 1'b0;
    b_start = 1'b0;
    cycles = 0;
    while (!(sel ? b_done : a_done) && cycles < 400) begin
      tick();
      cycles++;
    end
    if (!(sel ? b_done : a_done)) cycles = -1;
  endtask

  task automatic test_reset();
    checks++;
    if ({a_busy, a_done, a_pass, a_fv} !== 4'b0) begin
      failures++; $display("FAIL reset_flags got=%b want=0000", {a_busy, a_done, a_pass, a_fv});
    end
    checks++;
    if ({a_err, a_tested, a_ffi} !== 14'd0) begin
      failures++; $display("FAIL reset_counts got err=%0d tested=%0d ffi=%0d want 0", a_err, a_tested, a_ffi);
    end
    checks++;
    if ({a_addr, a_dut_in} !== 7'd0) begin
      failures++; $display("FAIL reset_addr_in got addr=%0d in=%0d want 0", a_addr, a_dut_in);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_zero_vectors();
    int cyc;
    run(1'b0, 5'd0, cyc);
    checks++;
    if (cyc !== 0) begin failures++; $display("FAIL zero_latency got=%0d want=0", cyc); end
    checks++;
    if ({a_pass, a_busy, a_tested, a_dut_in} !== {1'b1, 1'b0, 5'd0, 3'd0}) begin
      failures++; $display("FAIL zero_result got pass=%b busy=%b tested=%0d in=%0d want 1 0 0 0",
                           a_pass, a_busy, a_tested, a_dut_in);
    end
  endtask

  task automatic test_all_pass();
    int cyc;
    run(1'b0, 5'd8, cyc);
    checks++;
    if (cyc !== 32) begin failures++; $display("FAIL pass_latency got=%0d want=32", cyc); end
    checks++;
    if ({a_pass, a_fv, a_err, a_tested} !== {1'b1, 1'b0, 5'd0, 5'd8}) begin
      failures++; $display("FAIL pass_result got pass=%b fv=%b err=%0d tested=%0d want 1 0 0 8",
                           a_pass, a_fv, a_err, a_tested);
    end
    checks++;
    if (a_dut_in !== 3'd7) begin failures++; $display("FAIL pass_dut_in got=%0d want=7", a_dut_in); end
  endtask

  task automatic test_single_fail();
    int cyc;
    mem[5] = mem[5] ^ 4'b0001;
    run(1'b0, 5'd8, cyc);
    mem[5] = good_vec(5);
    checks++;
    if ({a_pass, a_fv, a_err, a_tested} !== {1'b0, 1'b1, 5'd1, 5'd8}) begin
      failures++; $display("FAIL single_result got pass=%b fv=%b err=%0d tested=%0d want 0 1 1 8",
                           a_pass, a_fv, a_err, a_tested);
    end
    checks++;
    if (a_ffi !== 4'd5) begin failures++; $display("FAIL single_first got=%0d want=5", a_ffi); end
  endtask

  task automatic test_stop_on_fail();
    int cyc;
    mem[2] = mem[2] ^ 4'b0001;
    mem[6] = mem[6] ^ 4'b0001;
    run(1'b1, 5'd8, cyc);
    mem[2] = good_vec(2);
    mem[6] = good_vec(6);
    checks++;
    if (cyc !== 18) begin failures++; $display("FAIL stop_latency got=%0d want=18", cyc); end
    checks++;
    if ({b_pass, b_err, b_tested, b_ffi} !== {1'b0, 5'd1, 5'd3, 4'd2}) begin
      failures++; $display("FAIL stop_result got pass=%b err=%0d tested=%0d ffi=%0d want 0 1 3 2",
                           b_pass, b_err, b_tested, b_ffi);
    end
  endtask

  task automatic test_settle_delay();
    int cyc;
    dly = 1'b1;
    run(1'b1, 5'd8, cyc);
    checks++;
    if ({b_pass, b_err, b_tested} !== {1'b1, 5'd0, 5'd8}) begin
      failures++; $display("FAIL settle3_result got pass=%b err=%0d tested=%0d want 1 0 8",
                           b_pass, b_err, b_tested);
    end
    run(1'b0, 5'd8, cyc);
    checks++;
    if (a_pass !== 1'b0 || a_err === 5'd0 || $isunknown(a_err) || a_tested !== 5'd8) begin
      failures++; $display("FAIL settle1_result got pass=%b err=%0d tested=%0d want 0 >0 8",
                           a_pass, a_err, a_tested);
    end
    dly = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    tick();
    a_num = 5'd8; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    repeat (18) tick();
    checks++;
    if ({a_busy, a_addr, a_dut_in} !== {1'b1, 4'd4, 3'd4}) begin
      failures++; $display("FAIL mid_position got busy=%b addr=%0d in=%0d want 1 4 4", a_busy, a_addr, a_dut_in);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({a_busy, a_done, a_pass, a_fv, a_err, a_tested, a_ffi, a_addr, a_dut_in} !== 26'd0) begin
      failures++; $display("FAIL mid_reset got busy=%b done=%b err=%0d tested=%0d addr=%0d in=%0d want all 0",
                           a_busy, a_done, a_err, a_tested, a_addr, a_dut_in);
    end
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if ({a_busy, a_done} !== 2'b00) begin
      failures++; $display("FAIL mid_idle got busy=%b done=%b want 0 0", a_busy, a_done);
    end
    // Restart, with a second start (num=2) pulsed while busy that must be ignored
    a_num = 5'd8; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    cyc = 0;
    while (!a_done && cyc < 400) begin
      a_start = (cyc == 5);
      a_num   = (cyc == 5) ? 5'd2 : 5'd8;
      tick();
      cyc++;
    end
    a_start = 1'b0;
    checks++;
    if (cyc !== 32) begin failures++; $display("FAIL ignore_latency got=%0d want=32", cyc); end
    checks++;
    if ({a_pass, a_err, a_tested} !== {1'b1, 5'd0, 5'd8}) begin
      failures++; $display("FAIL ignore_result got pass=%b err=%0d tested=%0d want 1 0 8",
                           a_pass, a_err, a_tested);
    end
  endtask

  task automatic test_clamp();
    int cyc;
    run(1'b0, 5'd31, cyc);
    checks++;
    if (cyc !== 64) begin failures++; $display("FAIL clamp_latency got=%0d want=64", cyc); end
    checks++;
    if ({a_pass, a_tested} !== {1'b1, 5'd16}) begin
      failures++; $display("FAIL clamp_result got pass=%b tested=%0d want 1 16", a_pass, a_tested);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = good_vec(i);
    tick();
    test_reset();
    test_zero_vectors();
    test_all_pass();
    test_single_fail();
    test_stop_on_fail();
    test_settle_delay();
    test_reset_mid_run();
    test_clamp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vector_test_controller.md
Name: vector_test_controller

Overview:
- Self-checking vector sequencer for small combinational blocks (NIN inputs, NOUT outputs).
- Fetches packed {inputs, expected} vectors from a synchronous-read vector memory and drives the inputs onto the DUT.
- Waits a programmable settle time, then compares the DUT outputs and accumulates pass/fail statistics.
- Used on-chip as a BIST-style controller and in benches in place of hand-written apply/check clock-edge loops.

Parameters:
- NIN, 3, DUT input width.
- NOUT, 1, DUT output width.
- DEPTH, 16, vector memory entries.
- AW, $clog2(DEPTH), vector index width.
- SETTLE, 1, cycles between applying inputs and sampling outputs (>=1).
- STOP_ON_FAIL, 0, 1 = end the run at the first mismatch.

Ports:
- clk, input, 1, clock, rising edge.
- reset, input, 1, asynchronous, active-high.
- start, input, 1, pulse; begins a run from IDLE or DONE, ignored while busy.
- num_vectors, input, AW+1, number of vectors to run (0..DEPTH); sampled on start.
- mem_addr, output, AW, vector memory read address.
- mem_rdata, input, NIN+NOUT, vector data, valid one cycle after mem_addr; bits [NIN+NOUT-1:NOUT] are inputs, [NOUT-1:0] are expected outputs.
- dut_in, output, NIN, registered stimulus to the DUT.
- dut_out, input, NOUT, DUT response.
- busy, output, 1, run in progress.
- done, output, 1, run finished; held until next start.
- pass, output, 1, valid when done; 1 iff err_count==0.
- err_count, output, AW+1, mismatch count.
- fail_valid, output, 1, at least one failure recorded.
- first_fail_idx, output, AW, index of first failing vector.
- tested_count, output, AW+1, vectors checked this run.

Behaviour:
- Reset (async): state=IDLE. All outputs 0, including mem_addr, dut_in, idx and captured num_vectors.
- FSM states: IDLE, FETCH, LOAD, WAIT, CHECK, DONE (enum in package).
- IDLE/DONE + start: clear err_count, tested_count, fail_valid and first_fail_idx; idx=0; latch num_vectors.
  - If latched num_vectors==0: go to DONE next cycle with pass=1, tested_count=0.
  - Otherwise go to FETCH.
- FETCH: mem_addr=idx. Go to LOAD.
- LOAD: dut_in <= mem_rdata[NIN+NOUT-1:NOUT]; exp <= mem_rdata[NOUT-1:0]; settle counter <= SETTLE-1. Go to WAIT.
- WAIT: stay while counter!=0, decrementing each cycle. Exit to CHECK when counter==0, so CHECK comes exactly SETTLE cycles after LOAD.
- CHECK: tested_count++.
  - Mismatch if dut_out != exp. Any X on dut_out counts as a mismatch in simulation (compare with !==).
  - On mismatch: err_count++ (saturates at all-ones). If !fail_valid, set first_fail_idx=idx and fail_valid=1.
  - Next state: DONE if (mismatch && STOP_ON_FAIL) or idx==num_vectors-1; otherwise idx++ and go to FETCH.
- Throughput: one vector every 3+SETTLE cycles (default 4).
- DONE: done=1, busy=0. pass=(err_count==0). dut_in holds the last vector.
- busy=1 in FETCH, LOAD, WAIT and CHECK; 0 otherwise. done=1 only in DONE.
- start while busy: ignored; no state or counter change.
- start in DONE: restarts identically to start from IDLE.
- num_vectors > DEPTH: clamp to DEPTH at latch.
- Reset mid-run: immediate return to IDLE with all outputs cleared; no partial result is retained.
- mem_addr is only meaningful in FETCH; it holds its value in other states.

Decomposition:
- Package vtc_pkg holds:
  - state_t enum {IDLE, FETCH, LOAD, WAIT, CHECK, DONE};
  - localparam function for vector width (NIN+NOUT).
- Sub-module vtc_result_tracker: owns err_count saturation, fail_valid/first_fail_idx capture and tested_count. Interface: clear, check_en, mismatch, idx.
- The top level contains the FSM, the settle counter and the dut_in/exp registers.

Test Plan:
- DUT model y=a^b^c; 8 correct vectors, num_vectors=8, SETTLE=1 -> done asserted 32 cycles after start; pass=1, err_count=0, tested_count=8, fail_valid=0.
- Same run with vector 5's expected bit flipped, STOP_ON_FAIL=0 -> pass=0, err_count=1, first_fail_idx=5, tested_count=8.
- Vectors 2 and 6 corrupted, STOP_ON_FAIL=1 -> done after vector 2; tested_count=3, err_count=1, first_fail_idx=2.
- num_vectors=0 -> done one cycle after start, pass=1, tested_count=0, dut_in stays 0.
- SETTLE=3 with the DUT output delayed 2 cycles -> all pass. SETTLE=1 with the same DUT -> mismatches detected, err_count>0.
- Reset pulsed mid-WAIT on vector 4 -> all outputs 0, state IDLE. Start pulsed during busy is ignored. A new start then runs a clean full pass.
